// File: rtl/max_select_seq_pkg.sv
// Shared definitions for the bit-serial maximum stage.
//   state_t    : FSM state encoding (IDLE, RUN, OUT)
//   clog2_min1 : ceil(log2(v)), never less than 1, used to size the chunk counter
package max_select_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   function automatic int clog2_min1(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/max_select_seq_cmp_lt_chunk.sv
// W-bit LSB-first unsigned less-than chain, one AND per bit.
//   a, b   : chunk of operand A and B (bit 0 is least significant)
//   lt_in  : running "A < B" result from the lower chunks
//   lt_out : running result after this chunk
// Each bit: where a and b differ, lt takes b; where equal, lt holds.
// Written as ((a^b) & (b^lt)) ^ lt so only the AND is a non-free gate.
module cmp_lt_chunk #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         lt_in,
   output logic         lt_out
);

   logic [W:0] c;

   assign c[0] = lt_in;

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign c[i+1] = ((a[i] ^ b[i]) & (b[i] ^ c[i])) ^ c[i];
   end

   assign lt_out = c[W];

endmodule

// File: rtl/max_select_seq.sv
// Sequential bit-serial maximum: latches A and B, compares them W bits per
// clock LSB-first, then registers S = (A < B) and O = max(A, B).
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   start : request, accepted only in IDLE (A and B sampled then)
//   A, B  : N-bit unsigned operands
//   busy  : high while in RUN and OUT
//   done  : one-cycle pulse, S and O valid from that cycle on
//   S     : 1 when A < B
//   O     : larger operand, held until the next done
module max_select_seq
   import max_select_seq_pkg::*;
#(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         S,
   output logic [N-1:0] O
);

   localparam int K  = (W > 0) ? (N / W) : 1;
   localparam int CW = clog2_min1(K);

   if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
      $error("max_select_seq: N must be a non-zero multiple of W and W <= N");
   end

   state_t        state;
   logic [N-1:0]  ra, rb;
   logic [CW-1:0] cnt;
   logic          lt, lt_next;

   // Single compare slice, steered onto the current chunk by cnt.
   cmp_lt_chunk #(.W(W)) u_cmp (
      .a      (ra[32'(cnt)*W +: W]),
      .b      (rb[32'(cnt)*W +: W]),
      .lt_in  (lt),
      .lt_out (lt_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         ra    <= '0;
         rb    <= '0;
         cnt   <= '0;
         lt    <= 1'b0;
         S     <= 1'b0;
         O     <= '0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  ra    <= A;
                  rb    <= B;
                  cnt   <= '0;
                  lt    <= 1'b0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               lt <= lt_next;
               if (cnt == CW'(K - 1)) state <= ST_OUT;
               else                   cnt   <= cnt + CW'(1);
            end
            ST_OUT: begin
               // XOR/AND select: B when lt is set, A otherwise.
               S     <= lt;
               O     <= ((ra ^ rb) & {N{lt}}) ^ ra;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_max_select_seq.sv
module tb_max_select_seq;

   logic        clk;
   logic        rst;
   logic        start32, start8;
   logic [31:0] a32, b32, o32;
   logic [7:0]  a8, b8, o8;
   logic        busy32, done32, s32;
   logic        busy8, done8, s8;

   int checks = 0;
   int errors = 0;

   max_select_seq #(.N(32), .W(8)) u32 (
      .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32),
      .busy(busy32), .done(done32), .S(s32), .O(o32)
   );

   max_select_seq #(.N(8), .W(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
      .busy(busy8), .done(done8), .S(s8), .O(o8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a start pulse on the 32-bit instance; returns just after the accepting edge.
   task automatic kick32(input logic [31:0] a, input logic [31:0] b);
      a32 = a; b32 = b; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
   endtask

   // Cycles from now until done32 is seen (bounded); -1 on timeout.
   task automatic wait32(output int lat);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done32) begin lat = i; break; end
      end
   endtask

   task automatic wait8(output int lat);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done8) begin lat = i; break; end
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({busy32, done32, s32, o32} !== 35'd0) begin
         errors++; $display("FAIL reset32: got busy=%b done=%b S=%b O=%h expected all 0", busy32, done32, s32, o32);
      end
      checks++;
      if ({busy8, done8, s8, o8} !== 11'd0) begin
         errors++; $display("FAIL reset8: got busy=%b done=%b S=%b O=%h expected all 0", busy8, done8, s8, o8);
      end
   endtask

   task automatic test_basic;
      int lat, nbusy;
      kick32(32'd5, 32'd9);
      nbusy = busy32 ? 1 : 0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done32) begin lat = i + 1; break; end
         if (busy32) nbusy++;
      end
      checks++;
      if (lat !== 6) begin errors++; $display("FAIL basic_latency: got %0d expected 6", lat); end
      checks++;
      if (nbusy !== 5) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 5", nbusy); end
      checks++;
      if (s32 !== 1'b1 || o32 !== 32'h9) begin
         errors++; $display("FAIL basic_result: got S=%b O=%h expected S=1 O=00000009", s32, o32);
      end
      checks++;
      if (busy32 !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy32); end
      @(posedge clk); #1;
      checks++;
      if (done32 !== 1'b0 || o32 !== 32'h9 || s32 !== 1'b1) begin
         errors++; $display("FAIL basic_done_pulse: got done=%b S=%b O=%h expected done=0 S=1 O=00000009", done32, s32, o32);
      end
   endtask

   task automatic test_msb;
      int lat;
      kick32(32'h8000_0000, 32'h7FFF_FFFF);
      wait32(lat);
      checks++;
      if (lat !== 5 || s32 !== 1'b0 || o32 !== 32'h8000_0000) begin
         errors++; $display("FAIL msb: got lat=%0d S=%b O=%h expected lat=5 S=0 O=80000000", lat, s32, o32);
      end
   endtask

   task automatic test_equal;
      int lat;
      kick32(32'hDEAD_BEEF, 32'hDEAD_BEEF);
      wait32(lat);
      checks++;
      if (lat !== 5 || s32 !== 1'b0 || o32 !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL equal: got lat=%0d S=%b O=%h expected lat=5 S=0 O=deadbeef", lat, s32, o32);
      end
   endtask

   task automatic test_start_while_busy;
      int lat, extra;
      kick32(32'd1, 32'd2);
      a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      wait32(lat);
      checks++;
      if (lat !== 4 || s32 !== 1'b1 || o32 !== 32'd2) begin
         errors++; $display("FAIL busy_start: got lat=%0d S=%b O=%h expected lat=4 S=1 O=00000002", lat, s32, o32);
      end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done32) extra++;
      end
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL busy_start_extra_done: got %0d expected 0", extra); end
   endtask

   task automatic test_reset_mid_run;
      int lat, ndone;
      kick32(32'h100, 32'h200);
      @(posedge clk); #1;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({busy32, done32, s32, o32} !== 35'd0) begin
         errors++; $display("FAIL mid_reset: got busy=%b done=%b S=%b O=%h expected all 0", busy32, done32, s32, o32);
      end
      #2 rst = 1'b1;
      @(posedge clk); #1;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         if (done32 || busy32) ndone++;
         @(posedge clk); #1;
      end
      checks++;
      if (ndone !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d active cycles expected 0", ndone); end
      kick32(32'd7, 32'd3);
      wait32(lat);
      checks++;
      if (lat !== 5 || s32 !== 1'b0 || o32 !== 32'd7) begin
         errors++; $display("FAIL after_reset: got lat=%0d S=%b O=%h expected lat=5 S=0 O=00000007", lat, s32, o32);
      end
   endtask

   task automatic test_back_to_back_k1;
      int lat;
      a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      checks++;
      if (busy8 !== 1'b1) begin errors++; $display("FAIL k1_busy: got %b expected 1", busy8); end
      wait8(lat);
      checks++;
      if (lat !== 2 || s8 !== 1'b1 || o8 !== 8'h20) begin
         errors++; $display("FAIL k1_result: got lat=%0d S=%b O=%h expected lat=2 S=1 O=20", lat, s8, o8);
      end
      // Start issued in the done cycle must be accepted.
      a8 = 8'h33; b8 = 8'h22; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
         errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy8, done8);
      end
      wait8(lat);
      checks++;
      if (lat !== 2 || s8 !== 1'b0 || o8 !== 8'h33) begin
         errors++; $display("FAIL b2b_result: got lat=%0d S=%b O=%h expected lat=2 S=0 O=33", lat, s8, o8);
      end
   endtask

   initial begin
      rst = 1'b0;
      start32 = 1'b0; start8 = 1'b0;
      a32 = '0; b32 = '0; a8 = '0; b8 = '0;
      #12;
      test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      test_basic();
      test_msb();
      test_equal();
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back_k1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
